// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared state encoding and master indices for wb_bus_arbiter
package wb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_INST,
        ARB_GNT_DATA
    } arb_state_t;

    localparam int M_INST = 0;
    localparam int M_DATA = 1;

    // On a simultaneous request: 1 selects the data master, 0 the instruction master.
    function automatic logic tie_pick_data(input logic fixed_prio, input logic last_owner);
        return fixed_prio | ~last_owner;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_watchdog.sv
// rtl/wb_bus_arbiter_watchdog.sv - stalled-strobe counter raising a one-cycle error pulse (WB_ARB_TIMEOUT_EN)
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic err_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] cnt_q, cnt_d;

    assign err_o = active_i & (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || err_o || ack_i) begin
            cnt_d = '0;
        end else if (stb_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master to one-slave Wishbone B4 classic arbiter; optional watchdog under WB_ARB_TIMEOUT_EN
import wb_bus_arbiter_pkg::*;

module wb_bus_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       m_cyc,
    input  logic [1:0]       m_stb,
    input  logic [1:0]       m_we,
    input  logic [1:0][31:0] m_adr,
    input  logic [1:0][31:0] m_dat_w,
    input  logic [1:0][3:0]  m_sel,
    output logic [31:0]      m_dat_r,
    output logic [1:0]       m_ack,
    output logic [1:0]       m_err,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [31:0]      s_adr,
    output logic [31:0]      s_dat_w,
    output logic [3:0]       s_sel,
    input  logic [31:0]      s_dat_r,
    input  logic             s_ack
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_t state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       granted;
    logic       owner;
    logic       own_cyc;
    logic       own_stb;
    logic       wd_err;

    assign granted = (state_q != ARB_IDLE);
    assign owner   = (state_q == ARB_GNT_DATA);
    assign own_cyc = granted & m_cyc[owner];
    assign own_stb = own_cyc & m_stb[owner];

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active_i (own_cyc),
        .stb_i    (own_stb),
        .ack_i    (s_ack),
        .err_o    (wd_err)
    );
`else
    assign wd_err = 1'b0;
`endif

    assign m_err   = {wd_err & owner, wd_err & ~owner};
    assign m_dat_r = s_dat_r;

    // Slave side follows the owner combinationally; a timed-out strobe is withheld for that cycle.
    always_comb begin
        s_cyc   = own_cyc;
        s_stb   = own_stb & ~wd_err;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_ack   = '0;
        if (granted) begin
            s_we    = m_we[owner];
            s_adr   = m_adr[owner];
            s_dat_w = m_dat_w[owner];
            s_sel   = m_sel[owner];
        end
        if (s_stb && s_ack) begin
            m_ack[owner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (&m_cyc) begin
                    state_d = tie_pick_data(FIXED_PRIO != 0, last_owner_q) ? ARB_GNT_DATA : ARB_GNT_INST;
                end else if (m_cyc[M_INST]) begin
                    state_d = ARB_GNT_INST;
                end else if (m_cyc[M_DATA]) begin
                    state_d = ARB_GNT_DATA;
                end
            end
            ARB_GNT_INST: begin
                if (!m_cyc[M_INST]) begin
                    last_owner_d = 1'b0;
                    state_d      = m_cyc[M_DATA] ? ARB_GNT_DATA : ARB_IDLE;
                end
            end
            ARB_GNT_DATA: begin
                if (!m_cyc[M_DATA]) begin
                    last_owner_d = 1'b1;
                    state_d      = m_cyc[M_INST] ? ARB_GNT_INST : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed table-driven bench for wb_bus_arbiter (round-robin and fixed-priority instances)
module tb_wb_bus_arbiter;

    localparam logic [31:0] ADR_I = 32'h0000_0100;
    localparam logic [31:0] ADR_D = 32'h0000_2000;
    localparam logic [31:0] DAT_I = 32'hAAAA_0000;
    localparam logic [31:0] DAT_D = 32'h1234_5678;
    localparam logic [3:0]  SEL_I = 4'b1111;
    localparam logic [3:0]  SEL_D = 4'b0011;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       m_cyc, m_stb, m_we;
    logic [1:0][31:0] m_adr, m_dat_w;
    logic [1:0][3:0]  m_sel;
    logic [31:0]      s_dat_r;
    logic             s_ack;

    logic [31:0] m_dat_r, s_adr, s_dat_w;
    logic [1:0]  m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;

    logic [31:0] fp_m_dat_r, fp_s_adr, fp_s_dat_w;
    logic [1:0]  fp_m_ack, fp_m_err;
    logic        fp_s_cyc, fp_s_stb, fp_s_we;
    logic [3:0]  fp_s_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_sel(s_sel), .s_dat_r(s_dat_r), .s_ack(s_ack)
    );

    wb_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(fp_m_dat_r), .m_ack(fp_m_ack), .m_err(fp_m_err),
        .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_adr(fp_s_adr), .s_dat_w(fp_s_dat_w),
        .s_sel(fp_s_sel), .s_dat_r(s_dat_r), .s_ack(s_ack)
    );

    // own / fp_own: 0 = idle, 1 = instruction master granted, 2 = data master granted
    typedef struct {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [1:0]  we;
        logic        ack;
        logic [31:0] sdr;
        int          own;
        logic        scyc;
        logic        sstb;
        logic [1:0]  mack;
        int          fp_own;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                                input logic [1:0] w, input logic a, input logic [31:0] d,
                                input int o, input logic sc, input logic ss,
                                input logic [1:0] ma, input int fo);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.ack = a; v.sdr = d;
        v.own = o; v.scyc = sc; v.sstb = ss; v.mack = ma; v.fp_own = fo;
        return v;
    endfunction

    function automatic logic [31:0] adr_of(input int o);
        return (o == 1) ? ADR_I : (o == 2) ? ADR_D : 32'h0;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   pulses;
        int   pulse_at;
        int   exp_pulses;
        int   exp_at;
        logic [31:0] e_dat;
        logic [3:0]  e_sel;
        logic        e_we;

        //             rst  cyc    stb    we     ack  s_dat_r        own scyc sstb mack  fp
        vecs[0]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0000_0000, 0, 0, 0, 2'b00, 0);
        vecs[1]  = mk(0, 2'b01, 2'b01, 2'b00, 0, 32'h0000_0001, 0, 0, 0, 2'b00, 0);
        vecs[2]  = mk(0, 2'b01, 2'b01, 2'b00, 0, 32'h0000_0002, 1, 1, 1, 2'b00, 1);
        vecs[3]  = mk(0, 2'b01, 2'b01, 2'b00, 1, 32'hDEAD_BEEF, 1, 1, 1, 2'b01, 1);
        vecs[4]  = mk(0, 2'b00, 2'b00, 2'b00, 0, 32'h0000_0004, 1, 0, 0, 2'b00, 1);
        vecs[5]  = mk(0, 2'b00, 2'b00, 2'b00, 0, 32'h0000_0005, 0, 0, 0, 2'b00, 0);
        vecs[6]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 32'h0000_0006, 0, 0, 0, 2'b00, 0);
        vecs[7]  = mk(0, 2'b11, 2'b11, 2'b10, 0, 32'h0000_0007, 0, 0, 0, 2'b00, 0);
        vecs[8]  = mk(0, 2'b11, 2'b11, 2'b10, 0, 32'h0000_0008, 1, 1, 1, 2'b00, 2);
        vecs[9]  = mk(0, 2'b11, 2'b11, 2'b10, 1, 32'hCAFE_0009, 1, 1, 1, 2'b01, 2);
        vecs[10] = mk(0, 2'b10, 2'b10, 2'b10, 0, 32'h0000_000A, 1, 0, 0, 2'b00, 2);
        vecs[11] = mk(0, 2'b11, 2'b11, 2'b10, 0, 32'h0000_000B, 2, 1, 1, 2'b00, 2);
        vecs[12] = mk(0, 2'b11, 2'b11, 2'b10, 1, 32'hF00D_000C, 2, 1, 1, 2'b10, 2);
        vecs[13] = mk(0, 2'b01, 2'b01, 2'b10, 0, 32'h0000_000D, 2, 0, 0, 2'b00, 2);
        vecs[14] = mk(0, 2'b01, 2'b01, 2'b10, 0, 32'h0000_000E, 1, 1, 1, 2'b00, 1);
        vecs[15] = mk(0, 2'b00, 2'b00, 2'b10, 0, 32'h0000_000F, 1, 0, 0, 2'b00, 1);
        vecs[16] = mk(0, 2'b00, 2'b00, 2'b10, 0, 32'h0000_0010, 0, 0, 0, 2'b00, 0);
        vecs[17] = mk(0, 2'b11, 2'b11, 2'b10, 0, 32'h0000_0011, 0, 0, 0, 2'b00, 0);
        vecs[18] = mk(0, 2'b11, 2'b11, 2'b10, 0, 32'h0000_0012, 2, 1, 1, 2'b00, 2);
        vecs[19] = mk(0, 2'b01, 2'b01, 2'b10, 0, 32'h0000_0013, 2, 0, 0, 2'b00, 2);
        vecs[20] = mk(0, 2'b01, 2'b00, 2'b00, 1, 32'h0000_0014, 1, 1, 0, 2'b00, 1);
        vecs[21] = mk(0, 2'b00, 2'b00, 2'b00, 1, 32'h0000_0015, 1, 0, 0, 2'b00, 1);
        vecs[22] = mk(0, 2'b00, 2'b00, 2'b00, 1, 32'h0000_0016, 0, 0, 0, 2'b00, 0);

        m_adr[0] = ADR_I;  m_adr[1] = ADR_D;
        m_dat_w[0] = DAT_I; m_dat_w[1] = DAT_D;
        m_sel[0] = SEL_I;  m_sel[1] = SEL_D;
        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_dat_r = '0;
        tick();
        tick();

        for (int i = 0; i < 23; i++) begin
            rst = vecs[i].rst; m_cyc = vecs[i].cyc; m_stb = vecs[i].stb; m_we = vecs[i].we;
            s_ack = vecs[i].ack; s_dat_r = vecs[i].sdr;
            #2;
            e_dat = (vecs[i].own == 1) ? DAT_I : (vecs[i].own == 2) ? DAT_D : 32'h0;
            e_sel = (vecs[i].own == 1) ? SEL_I : (vecs[i].own == 2) ? SEL_D : 4'h0;
            e_we  = (vecs[i].own == 1) ? vecs[i].we[0] : (vecs[i].own == 2) ? vecs[i].we[1] : 1'b0;
            chk("s_cyc",    i, 32'(s_cyc),   32'(vecs[i].scyc));
            chk("s_stb",    i, 32'(s_stb),   32'(vecs[i].sstb));
            chk("s_we",     i, 32'(s_we),    32'(e_we));
            chk("s_adr",    i, s_adr,        adr_of(vecs[i].own));
            chk("s_dat_w",  i, s_dat_w,      e_dat);
            chk("s_sel",    i, 32'(s_sel),   32'(e_sel));
            chk("m_ack",    i, 32'(m_ack),   32'(vecs[i].mack));
            chk("m_err",    i, 32'(m_err),   32'h0);
            chk("m_dat_r",  i, m_dat_r,      vecs[i].sdr);
            chk("fp_s_adr", i, fp_s_adr,     adr_of(vecs[i].fp_own));
            tick();
        end

        // Reset while the data master holds the bus, before its ack.
        rst = 1'b0; s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
        #2 chk("rst_seq_idle_cyc", 0, 32'(s_cyc), 32'h0);
        tick();
        rst = 1'b1;
        #2 chk("rst_seq_gnt_cyc", 1, 32'(s_cyc), 32'h1);
        chk("rst_seq_gnt_adr", 1, s_adr, ADR_D);
        tick();
        rst = 1'b0; s_ack = 1'b1;
        #2 chk("rst_seq_after_cyc", 2, 32'(s_cyc), 32'h0);
        chk("rst_seq_after_ack", 2, 32'(m_ack), 32'h0);
        chk("rst_seq_after_adr", 2, s_adr, 32'h0);
        tick();
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        tick();
        tick();

        // Stuck slave: instruction master strobes and never gets an ack.
        pulses = 0; pulse_at = -1;
        m_cyc = 2'b01; m_stb = 2'b01;
        for (int k = 0; k < 14; k++) begin
            #2;
            if (m_err != 2'b00) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
                chk("wd_err_value", k, 32'(m_err), 32'h1);
                chk("wd_stb_forced", k, 32'(s_stb), 32'h0);
            end
            tick();
        end
`ifdef WB_ARB_TIMEOUT_EN
        exp_pulses = 1; exp_at = 9;
`else
        exp_pulses = 0; exp_at = -1;
`endif
        chk("wd_pulse_count", 0, 32'(pulses), 32'(exp_pulses));
        chk("wd_pulse_cycle", 0, 32'(pulse_at), 32'(exp_at));
        #2 chk("wd_grant_kept", 0, 32'(s_cyc), 32'h1);
        tick();
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        #2 chk("wd_release_idle", 0, 32'(s_cyc), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
